// File: rtl/dual_clock_fwft_fifo.sv
`timescale 1ns/1ps
// rtl/dual_clock_fwft_fifo.sv - dual-clock FIFO with show-ahead output, credit-based read prefetch
module dual_clock_fwft_fifo #(
    parameter int WIDTH              = 32,
    parameter int DEPTH_LOG2         = 9,
    parameter int ALMOST_FULL_MARGIN = 16,
    parameter int READ_LATENCY       = 2,
    parameter int SYNC_STAGES        = 3
) (
    input  logic                  wrclk,
    input  logic                  rst,
    input  logic                  writeEnable,
    input  logic [WIDTH-1:0]      dataIn,
    output logic                  full,
    output logic                  almostFull,
    output logic [DEPTH_LOG2:0]   wrUsedWords,
    output logic                  overflow,
    output logic                  resetBusy,
    input  logic                  rdclk,
    input  logic                  readAck,
    output logic [WIDTH-1:0]      dataOut,
    output logic                  dataOutValid
);
    localparam int AW    = DEPTH_LOG2;
    localparam int DEPTH = 1 << AW;
    localparam int NB    = READ_LATENCY + 1;
    localparam int BW    = $clog2(NB);
    localparam int CW    = $clog2(NB + 1);
    localparam logic [AW:0]   DEPTH_W  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   MARGIN_W = (AW+1)'(ALMOST_FULL_MARGIN);
    localparam logic [BW-1:0] LAST_IDX = BW'(NB - 1);

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [WIDTH-1:0] mem_q [DEPTH];

    // ---------------- write domain ----------------
    logic [AW:0]            wr_ptr_q, wr_gray_q, used_q;
    logic [AW:0]            rd_gray_sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] rst_ret_sync_q;
    logic                   rst_fwd_q, reset_busy_q, full_q, almost_full_q, overflow_q;
    logic                   wr_accept, rst_ret;
    logic [AW:0]            wr_ptr_d, sync_rd_ptr, used_d;

    // ---------------- read domain -----------------
    logic [SYNC_STAGES-1:0] rd_rst_sync_q;
    logic [AW:0]            wr_gray_sync_q [SYNC_STAGES];
    logic [AW:0]            rd_ptr_q, rd_gray_q, rd_ptr_d, sync_wr_ptr;
    logic [CW-1:0]          credits_q, count_q;
    logic [BW-1:0]          head_q, tail_q;
    logic [READ_LATENCY-1:0] pipe_vld_q;
    logic [WIDTH-1:0]       pipe_data_q [READ_LATENCY];
    logic [WIDTH-1:0]       buf_q [NB];
    logic                   rd_rst, issue, pop, push;

    assign rst_ret     = rst_ret_sync_q[SYNC_STAGES-1];
    assign sync_rd_ptr = gray2bin(rd_gray_sync_q[SYNC_STAGES-1]);
    assign wr_accept   = writeEnable && !full_q && !reset_busy_q;
    assign wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, wr_accept};
    assign used_d      = wr_ptr_d - sync_rd_ptr;

    // RAM write port
    always_ff @(posedge wrclk) begin
        if (wr_accept) mem_q[wr_ptr_q[AW-1:0]] <= dataIn;
    end

    // Write pointer and write-side status flags
    always_ff @(posedge wrclk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            wr_gray_q     <= '0;
            used_q        <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            wr_gray_q     <= bin2gray(wr_ptr_d);
            used_q        <= used_d;
            full_q        <= (used_d == DEPTH_W);
            almost_full_q <= ((DEPTH_W - used_q) <= MARGIN_W);
            if (writeEnable && full_q && !reset_busy_q) overflow_q <= 1'b1;
        end
    end

    // Reset handshake: hold the forwarded reset until the read side echoes it, then wait for the echo to clear
    always_ff @(posedge wrclk) begin
        if (rst) begin
            rst_fwd_q    <= 1'b1;
            reset_busy_q <= 1'b1;
        end else begin
            if (rst_ret) rst_fwd_q <= 1'b0;
            if (!rst_fwd_q && !rst_ret) reset_busy_q <= 1'b0;
        end
    end

    // Bring the read-side reset back into wrclk
    always_ff @(posedge wrclk) begin
        rst_ret_sync_q <= {rst_ret_sync_q[SYNC_STAGES-2:0], rd_rst};
    end

    // Read pointer synchronizer; held at zero until the read side is known to be reset
    always_ff @(posedge wrclk) begin
        if (rst || reset_busy_q) begin
            for (int i = 0; i < SYNC_STAGES; i++) rd_gray_sync_q[i] <= '0;
        end else begin
            rd_gray_sync_q[0] <= rd_gray_q;
            for (int i = 1; i < SYNC_STAGES; i++) rd_gray_sync_q[i] <= rd_gray_sync_q[i-1];
        end
    end

    assign rd_rst      = rd_rst_sync_q[SYNC_STAGES-1];
    assign sync_wr_ptr = gray2bin(wr_gray_sync_q[SYNC_STAGES-1]);
    assign pop         = readAck && (count_q != '0);
    assign issue       = (sync_wr_ptr != rd_ptr_q) && ((credits_q != '0) || pop);
    assign push        = pipe_vld_q[READ_LATENCY-1];
    assign rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, issue};

    // Reset into rdclk; rst is ORed in so a fresh reset reaches the read side without the extra register
    always_ff @(posedge rdclk) begin
        rd_rst_sync_q <= {rd_rst_sync_q[SYNC_STAGES-2:0], rst | rst_fwd_q};
    end

    // Write pointer synchronizer
    always_ff @(posedge rdclk) begin
        if (rd_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) wr_gray_sync_q[i] <= '0;
        end else begin
            wr_gray_sync_q[0] <= wr_gray_q;
            for (int i = 1; i < SYNC_STAGES; i++) wr_gray_sync_q[i] <= wr_gray_sync_q[i-1];
        end
    end

    // RAM read data pipeline models the address-to-data latency
    always_ff @(posedge rdclk) begin
        pipe_data_q[0] <= mem_q[rd_ptr_q[AW-1:0]];
        for (int i = 1; i < READ_LATENCY; i++) pipe_data_q[i] <= pipe_data_q[i-1];
    end

    // Valid tags for in-flight reads; cleared on reset so nothing stale lands in the buffer
    always_ff @(posedge rdclk) begin
        if (rd_rst) begin
            pipe_vld_q <= '0;
        end else begin
            pipe_vld_q[0] <= issue;
            for (int i = 1; i < READ_LATENCY; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
        end
    end

    // Output buffer storage
    always_ff @(posedge rdclk) begin
        if (push) buf_q[tail_q] <= pipe_data_q[READ_LATENCY-1];
    end

    // Read pointer, credits and output buffer bookkeeping
    always_ff @(posedge rdclk) begin
        if (rd_rst) begin
            rd_ptr_q  <= '0;
            rd_gray_q <= '0;
            credits_q <= CW'(NB);
            count_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            rd_gray_q <= bin2gray(rd_ptr_d);
            credits_q <= credits_q + CW'(pop) - CW'(issue);
            count_q   <= count_q + CW'(push) - CW'(pop);
            if (pop)  head_q <= (head_q == LAST_IDX) ? '0 : head_q + 1'b1;
            if (push) tail_q <= (tail_q == LAST_IDX) ? '0 : tail_q + 1'b1;
        end
    end

    assign full         = full_q;
    assign almostFull   = almost_full_q;
    assign wrUsedWords  = used_q;
    assign overflow     = overflow_q;
    assign resetBusy    = reset_busy_q;
    assign dataOutValid = (count_q != '0);
    assign dataOut      = dataOutValid ? buf_q[head_q] : '0;
endmodule

// File: tb/tb_dual_clock_fwft_fifo.sv
`timescale 1ns/1ps
// tb/tb_dual_clock_fwft_fifo.sv - directed self-checking bench for dual_clock_fwft_fifo
module tb_dual_clock_fwft_fifo;
    localparam int WIDTH = 32;
    localparam int DL    = 5;
    localparam int RL    = 2;
    localparam int SS    = 3;
    localparam int AFM   = 8;

    logic             wrclk = 1'b0;
    logic             rdclk = 1'b0;
    logic             rst = 1'b1;
    logic             writeEnable = 1'b0;
    logic             readAck = 1'b0;
    logic [WIDTH-1:0] dataIn = '0;
    logic [WIDTH-1:0] dataOut;
    logic             full, almostFull, overflow, resetBusy, dataOutValid;
    logic [DL:0]      wrUsedWords;

    real wr_half = 5.0;
    real rd_half = 5.0;
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  tog_on = 1'b0;
    logic [WIDTH-1:0] sb [$];

    always #(wr_half) wrclk = ~wrclk;
    always #(rd_half) rdclk = ~rdclk;

    dual_clock_fwft_fifo #(
        .WIDTH(WIDTH), .DEPTH_LOG2(DL), .ALMOST_FULL_MARGIN(AFM),
        .READ_LATENCY(RL), .SYNC_STAGES(SS)
    ) dut (
        .wrclk(wrclk), .rst(rst), .writeEnable(writeEnable), .dataIn(dataIn),
        .full(full), .almostFull(almostFull), .wrUsedWords(wrUsedWords),
        .overflow(overflow), .resetBusy(resetBusy),
        .rdclk(rdclk), .readAck(readAck), .dataOut(dataOut), .dataOutValid(dataOutValid)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        int k;
        @(negedge wrclk);
        rst = 1'b1;
        writeEnable = 1'b0;
        repeat (4) @(negedge wrclk);
        rst = 1'b0;
        k = 0;
        while (resetBusy && k < 60) begin
            @(negedge wrclk);
            k++;
        end
        check_eq("reset_busy_clears", 64'(resetBusy), 64'd0);
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!dataOutValid && k < 30) begin
            @(negedge rdclk);
            k++;
        end
        check_eq(tag, 64'(dataOutValid), 64'd1);
    endtask

    task automatic write_burst(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            @(negedge wrclk);
            writeEnable = 1'b1;
            dataIn = 32'(base + i);
        end
        @(negedge wrclk);
        writeEnable = 1'b0;
    endtask

    initial begin
        int n;
        int got;
        logic [WIDTH-1:0] exp;

        // reset state
        repeat (3) @(negedge wrclk);
        check_eq("rst_full", 64'(full), 64'd0);
        check_eq("rst_almost_full", 64'(almostFull), 64'd0);
        check_eq("rst_used", 64'(wrUsedWords), 64'd0);
        check_eq("rst_overflow", 64'(overflow), 64'd0);
        check_eq("rst_busy_high", 64'(resetBusy), 64'd1);
        repeat (3) @(negedge wrclk);
        check_eq("rst_valid", 64'(dataOutValid), 64'd0);
        check_eq("rst_data_zero", 64'(dataOut), 64'd0);
        rst = 1'b0;
        @(negedge wrclk);
        check_eq("rst_busy_after_release", 64'(resetBusy), 64'd1);
        n = 0;
        while (resetBusy && n < 60) begin @(negedge wrclk); n++; end
        check_eq("rst_busy_low", 64'(resetBusy), 64'd0);

        // streaming 0..99 with readAck held high
        readAck = 1'b1;
        fork
            write_burst(100, 0);
            begin
                int m;
                m = 0;
                do begin @(negedge rdclk); m++; end while (!dataOutValid && m < 20);
                // first write edge follows the first counted negedge; allow SS+RL+3 cycles after it
                check_eq("t1_first_latency", 64'(m <= SS + RL + 5), 64'd1);
                for (int k = 0; k < 100; k++) begin
                    check_eq("t1_no_gap", 64'(dataOutValid), 64'd1);
                    check_eq("t1_data", 64'(dataOut), 64'(k));
                    @(negedge rdclk);
                end
            end
        join
        repeat (12) @(negedge wrclk);
        check_eq("t1_used_empty", 64'(wrUsedWords), 64'd0);
        check_eq("t1_valid_empty", 64'(dataOutValid), 64'd0);
        check_eq("t1_overflow", 64'(overflow), 64'd0);

        // fill past capacity with no reads: 32 in RAM, 3 prefetched, 5 dropped
        @(negedge rdclk);
        readAck = 1'b0;
        write_burst(40, 1000);
        repeat (12) @(negedge wrclk);
        check_eq("t2_full", 64'(full), 64'd1);
        check_eq("t2_used", 64'(wrUsedWords), 64'd32);
        check_eq("t2_overflow", 64'(overflow), 64'd1);
        check_eq("t2_almost_full", 64'(almostFull), 64'd1);
        check_eq("t2_head", 64'(dataOut), 64'd1000);
        readAck = 1'b1;
        for (int k = 0; k < 35; k++) begin
            wait_valid("t2_drain_valid");
            check_eq("t2_drain_data", 64'(dataOut), 64'(1000 + k));
            @(negedge rdclk);
        end
        repeat (20) @(negedge rdclk);
        check_eq("t2_no_extra", 64'(dataOutValid), 64'd0);
        check_eq("t2_used_zero", 64'(wrUsedWords), 64'd0);
        check_eq("t2_full_clear", 64'(full), 64'd0);
        check_eq("t2_overflow_sticky", 64'(overflow), 64'd1);

        // almostFull threshold at 24 words in RAM (margin 8)
        readAck = 1'b0;
        for (int k = 1; k <= 27; k++) begin
            @(negedge wrclk);
            writeEnable = 1'b1;
            dataIn = 32'(2000 + k);
            @(negedge wrclk);
            writeEnable = 1'b0;
            if (k == 27) begin
                check_eq("t3_used_24", 64'(wrUsedWords), 64'd24);
                check_eq("t3_af_not_yet", 64'(almostFull), 64'd0);
                @(negedge wrclk);
                check_eq("t3_af_rise", 64'(almostFull), 64'd1);
            end else begin
                repeat (12) @(negedge wrclk);
                if (k == 3)  check_eq("t3_used_prefetched", 64'(wrUsedWords), 64'd0);
                if (k == 26) begin
                    check_eq("t3_used_23", 64'(wrUsedWords), 64'd23);
                    check_eq("t3_af_low_23", 64'(almostFull), 64'd0);
                end
            end
        end
        @(negedge rdclk);
        readAck = 1'b1;
        @(negedge rdclk);
        readAck = 1'b0;
        check_eq("t3_af_hold", 64'(almostFull), 64'd1);
        n = 0;
        while (almostFull && n < 15) begin @(negedge wrclk); n++; end
        check_eq("t3_af_fall", 64'(almostFull), 64'd0);
        check_eq("t3_used_back_23", 64'(wrUsedWords), 64'd23);
        check_eq("t3_head_next", 64'(dataOut), 64'd2002);
        readAck = 1'b1;
        repeat (60) @(negedge rdclk);
        readAck = 1'b0;
        check_eq("t3_drained", 64'(dataOutValid), 64'd0);
        check_eq("t3_used_drained", 64'(wrUsedWords), 64'd0);

        // readAck on an empty FIFO must be ignored
        for (int k = 0; k < 10; k++) begin
            @(negedge rdclk);
            readAck = ~readAck;
        end
        @(negedge rdclk);
        readAck = 1'b0;
        check_eq("t4_empty_valid", 64'(dataOutValid), 64'd0);
        write_burst(1, 32'h1234);
        wait_valid("t4_valid");
        check_eq("t4_data", 64'(dataOut), 64'h1234);
        readAck = 1'b1;
        repeat (15) @(negedge rdclk);
        readAck = 1'b0;
        check_eq("t4_single", 64'(dataOutValid), 64'd0);

        // reset while 20 words are buffered and readAck toggles
        write_burst(20, 32'h500);
        repeat (12) @(negedge wrclk);
        check_eq("t5_head", 64'(dataOut), 64'h500);
        tog_on = 1'b1;
        fork
            begin
                while (tog_on) begin
                    @(negedge rdclk);
                    readAck = ~readAck;
                end
            end
        join_none
        repeat (2) @(negedge wrclk);
        rst = 1'b1;
        n = 0;
        while (dataOutValid && n < 12) begin @(negedge rdclk); n++; end
        check_eq("t5_valid_drop_time", 64'(n <= SS + 1), 64'd1);
        check_eq("t5_busy_in_rst", 64'(resetBusy), 64'd1);
        repeat (2) @(negedge wrclk);
        rst = 1'b0;
        n = 0;
        while (n < 60) begin
            @(negedge wrclk);
            if (!resetBusy) break;
            writeEnable = 1'b1;
            dataIn = 32'hDEAD;
            n++;
        end
        writeEnable = 1'b0;
        check_eq("t5_busy_low", 64'(resetBusy), 64'd0);
        tog_on = 1'b0;
        repeat (3) @(negedge rdclk);
        readAck = 1'b0;
        repeat (12) @(negedge wrclk);
        check_eq("t5_no_stale", 64'(dataOutValid), 64'd0);
        check_eq("t5_used_zero", 64'(wrUsedWords), 64'd0);
        check_eq("t5_overflow_cleared", 64'(overflow), 64'd0);
        write_burst(1, 32'hABCD);
        wait_valid("t5_valid");
        check_eq("t5_first_word", 64'(dataOut), 64'hABCD);
        readAck = 1'b1;
        repeat (15) @(negedge rdclk);
        readAck = 1'b0;
        check_eq("t5_only_word", 64'(dataOutValid), 64'd0);

        // unequal clocks, random traffic, 10000 words through the scoreboard
        wr_half = 2.0;
        rd_half = 2.89;
        do_reset();
        got = 0;
        fork
            begin
                int sent;
                sent = 0;
                while (sent < 10000) begin
                    @(negedge wrclk);
                    if (!almostFull && $urandom_range(3) != 0) begin
                        writeEnable = 1'b1;
                        dataIn = $urandom;
                        sb.push_back(dataIn);
                        sent++;
                    end else begin
                        writeEnable = 1'b0;
                    end
                end
                @(negedge wrclk);
                writeEnable = 1'b0;
            end
            begin
                int cyc;
                cyc = 0;
                while (got < 10000 && cyc < 60000) begin
                    @(negedge rdclk);
                    cyc++;
                    readAck = ($urandom_range(3) != 0);
                    if (dataOutValid && readAck) begin
                        if (sb.size() == 0) begin
                            check_eq("t6_underflow", 64'd1, 64'd0);
                        end else begin
                            exp = sb.pop_front();
                            check_eq("t6_data", 64'(dataOut), 64'(exp));
                        end
                        got++;
                    end
                end
                @(negedge rdclk);
                readAck = 1'b0;
            end
        join
        check_eq("t6_count", 64'(got), 64'd10000);
        check_eq("t6_sb_empty", 64'(sb.size()), 64'd0);
        check_eq("t6_overflow", 64'(overflow), 64'd0);
        repeat (20) @(negedge wrclk);
        check_eq("t6_used_zero", 64'(wrUsedWords), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dual_clock_fwft_fifo.md
Name: dual_clock_fwft_fifo

Overview:
- Next-generation dual-clock FIFO for crossing result/bot streams between the compute clock and the PCIe/host clock.
- Replaces the fixed-latency read interface with a first-word-fall-through (show-ahead) output.
- Adds a programmable almost-full margin, a write-side fill level, full, sticky overflow, and a single write-domain reset forwarded internally to the read domain.
- Memory read latency is a parameter, so the block maps onto both MLAB and M20K.

Parameters:
- WIDTH, 32, data word width.
- DEPTH_LOG2, 9, log2 of memory capacity (2^DEPTH_LOG2 words).
- ALMOST_FULL_MARGIN, 16, almostFull asserts when free RAM slots <= this value; legal range 1..2^DEPTH_LOG2-1.
- READ_LATENCY, 2, memory address-to-data latency in rdclk cycles; legal range 1..4.
- SYNC_STAGES, 3, gray-code / reset synchronizer depth; must be >= 2.

Ports:
- wrclk  in  1  write-domain clock.
- rst  in  1  synchronous active-high reset, wrclk domain; internally synchronized to rdclk.
- writeEnable  in  1  push dataIn.
- dataIn  in  WIDTH  write data.
- full  out  1  RAM full, wrclk, registered.
- almostFull  out  1  registered, wrclk.
- wrUsedWords  out  DEPTH_LOG2+1  RAM occupancy seen from the write side, pessimistic.
- overflow  out  1  sticky; a write was dropped.
- resetBusy  out  1  wrclk; high while the reset handshake is in progress.
- rdclk  in  1  read-domain clock.
- readAck  in  1  consume the current head word.
- dataOut  out  WIDTH  head word; forced to 0 when !dataOutValid.
- dataOutValid  out  1  head word present.

Behaviour:
- Reset, wrclk domain:
  - writePtr=0; full=0; almostFull=0; wrUsedWords=0; overflow=0; resetBusy=1.
  - rst is passed through SYNC_STAGES rdclk flops to form rdRst.
- Reset, rdclk domain, on rdRst:
  - readPtr=0; output buffer emptied; in-flight reads discarded; dataOutValid=0; dataOut=0.
- Reset handshake:
  - rdRst is synchronized back to wrclk.
  - resetBusy deasserts on the first wrclk cycle in which rst is low and the returned rdRst is low.
- Reset mid-operation: rst asserted during traffic (either domain busy) must behave exactly like reset from idle. All data is discarded and no stale word ever reaches dataOutValid.
- Writes during resetBusy are dropped. They do not set overflow and do not move writePtr.
- Pointers:
  - DEPTH_LOG2+1 bits binary; MSB is the wrap bit.
  - Crossed as gray code through SYNC_STAGES flops each way.
  - RAM address = low DEPTH_LOG2 bits.
- Write side:
  - wrUsedWords = writePtr - syncReadPtr, registered.
  - full = (wrUsedWords == 2^DEPTH_LOG2), including the current cycle's write.
  - almostFull = (2^DEPTH_LOG2 - wrUsedWords <= ALMOST_FULL_MARGIN), registered one cycle after the pointer update.
  - A write is accepted iff writeEnable && !full && !resetBusy.
  - writeEnable && full drops the word and sets overflow=1 until rst.
  - Wrap-around: pointer arithmetic is modulo 2^(DEPTH_LOG2+1); capacity is exactly 2^DEPTH_LOG2 words.
- Read side (FWFT):
  - The output buffer holds READ_LATENCY+1 words; a credit counter tracks free buffer slots minus in-flight reads.
  - A RAM read is issued when syncWritePtr != readPtr && credits > 0; readPtr increments on issue, freeing the RAM slot.
  - Data returning after READ_LATENCY cycles enters the output buffer.
  - dataOut/dataOutValid show the buffer head.
  - readAck && dataOutValid pops the head and returns one credit. readAck while !dataOutValid is ignored.
  - Sustained throughput is one word per rdclk cycle.
  - Issue and pop in the same cycle leave credits unchanged.
- Total storage is 2^DEPTH_LOG2 + READ_LATENCY + 1 words.
- Latency: a word written at wrclk edge W (equal clocks) has dataOutValid=1 no later than SYNC_STAGES+READ_LATENCY+3 rdclk cycles later, when the FIFO was otherwise empty.
- Ordering: words emerge in write order, none duplicated or lost, except those counted by overflow.

Test Plan:
- Equal clocks, DEPTH_LOG2=5, READ_LATENCY=2, SYNC_STAGES=3, readAck held 1; write 100 sequential words 0..99 -> dataOut shows 0..99 in order; first dataOutValid within 8 cycles of the first write; no gaps once streaming.
- readAck=0, write 40 words into DEPTH_LOG2=5 -> 32 stored in RAM, 3 in the output buffer, 5 dropped; full=1; wrUsedWords=32; overflow=1. Then drain -> exactly words 0..34 emerge.
- ALMOST_FULL_MARGIN=8, readAck=0, single writes -> almostFull rises the cycle after wrUsedWords reaches 24, not before; it falls after reads drop wrUsedWords back to 23 plus the sync delay.
- Wrap test: 10000 words, wrclk 250MHz / rdclk 173MHz, random writeEnable and readAck -> scoreboard matches exactly, overflow=0 under almostFull flow control.
- Assert rst while 20 words are buffered and readAck is toggling -> dataOutValid=0 within SYNC_STAGES+1 rdclk cycles; resetBusy high, then low; writes during resetBusy are ignored; the subsequent word 0xABCD is the first output.
- readAck pulses with dataOutValid=0 on an empty FIFO -> no pointer movement; the next written word still emerges intact.
